// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu : 16-bit registered ALU for the MIPS datapath.
//
// One operation is launched per accepted `start`, selected by `Aluctrl`.
// Logic, shift, compare and add operations finish at the accepting edge.
// An unsigned multiply runs as a shift-add sequence with one partial product
// per clock. It produces a 2*WIDTH product on `mulreg` and its low half on
// `dout`.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; single-cycle ops are executed here
// S_MUL  | shift-add multiply in progress, start is ignored
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset (aborts an in-flight multiply)
//   start     launch request, sampled only in S_IDLE
//   Aluctrl   operation select (0..F, all defined)
//   din1      operand A
//   din2      operand B; din2[3:0] is the shift amount
//   dout      registered result
//   mulreg    registered full product of the last multiply
//   done      one-cycle completion pulse
//   zeroflag  set when the value written to dout is zero
//   busy      high while a multiply is in progress
// ----------------------------------------------------------------------------
module alu #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         Aluctrl,
    input  logic [WIDTH-1:0]   din1,
    input  logic [WIDTH-1:0]   din2,
    output logic [WIDTH-1:0]   dout,
    output logic [2*WIDTH-1:0] mulreg,
    output logic               done,
    output logic               zeroflag,
    output logic               busy
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_SLTU = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_NOT  = 4'hC;
    localparam logic [3:0] OP_PASS = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;
    localparam logic [3:0] OP_DEC  = 4'hF;

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   result;
    logic [3:0]         shamt;
    logic               accept;
    logic               mul_last;

    assign shamt    = din2[3:0];
    assign accept   = start && (state == S_IDLE);
    assign mul_last = (state == S_MUL) && (cnt == '0);
    assign busy     = (state == S_MUL);

    // Partial product for this clock; on the last step it is the final product.
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && (Aluctrl == OP_MUL)) state_nxt = S_MUL;
            S_MUL:   if (mul_last)                      state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        result = '0;
        case (Aluctrl)
            OP_ADD:  result = din1 + din2;
            OP_SUB:  result = din1 - din2;
            OP_AND:  result = din1 & din2;
            OP_OR:   result = din1 | din2;
            OP_XOR:  result = din1 ^ din2;
            OP_NOR:  result = ~(din1 | din2);
            OP_SLL:  result = din1 << shamt;
            OP_SRL:  result = din1 >> shamt;
            OP_SRA:  result = $unsigned($signed(din1) >>> shamt);
            OP_SLT:  result = ($signed(din1) < $signed(din2)) ? ONE : '0;
            OP_SLTU: result = (din1 < din2) ? ONE : '0;
            OP_NOT:  result = ~din1;
            OP_PASS: result = din2;
            OP_INC:  result = din1 + ONE;
            OP_DEC:  result = din1 - ONE;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            mulreg   <= '0;
            done     <= 1'b0;
            zeroflag <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    if (Aluctrl == OP_MUL) begin
                        // Operands are latched so din1/din2 may change while busy.
                        mcand  <= {{WIDTH{1'b0}}, din1};
                        mplier <= din2;
                        acc    <= '0;
                        cnt    <= CNT_LOAD;
                    end else begin
                        dout     <= result;
                        zeroflag <= (result == '0);
                        done     <= 1'b1;
                    end
                end
            end else begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_ONE;
                if (cnt == '0) begin
                    mulreg   <= acc_nxt;
                    dout     <= acc_nxt[WIDTH-1:0];
                    zeroflag <= (acc_nxt[WIDTH-1:0] == '0);
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu : directed self-checking bench for alu.
// Inputs are driven on the falling edge, and outputs are sampled 1 ns after
// the rising edge.
// ----------------------------------------------------------------------------
module tb_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  Aluctrl;
    logic [15:0] din1;
    logic [15:0] din2;
    logic [15:0] dout;
    logic [31:0] mulreg;
    logic        done;
    logic        zeroflag;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    alu #(.WIDTH(16), .MUL_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Aluctrl  (Aluctrl),
        .din1     (din1),
        .din2     (din2),
        .dout     (dout),
        .mulreg   (mulreg),
        .done     (done),
        .zeroflag (zeroflag),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one single-cycle op and sample right after the accepting edge.
    task automatic single_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1; Aluctrl = op; din1 = a; din2 = b;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Launch a multiply and return the number of edges from accept to done.
    // Between edges, inputs are scrambled and start is toggled while busy.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           output int lat, output int busy_cnt, output logic [15:0] dout_seen);
        bit got;
        lat = 0; busy_cnt = 0; got = 0;
        @(negedge clk);
        start = 1'b1; Aluctrl = 4'hB; din1 = a; din2 = b;
        @(posedge clk); #1;
        if (busy) busy_cnt++;
        dout_seen = dout;
        while (!got && lat < 40) begin
            @(negedge clk);
            start   = lat[0];
            Aluctrl = 4'(lat);
            din1    = 16'($urandom);
            din2    = 16'($urandom);
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
            else if (busy) begin
                busy_cnt++;
                if (dout !== dout_seen) dout_seen = 16'hDEAD;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [3:0]  sw_op  [15] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [15:0] sw_exp [15] = '{16'hFF04, 16'hFF02, 16'h0001, 16'hFF03, 16'hFF02,
                                 16'h00FC, 16'hFE06, 16'h7F81, 16'hFF81, 16'h0001,
                                 16'h0000, 16'h00FC, 16'h0001, 16'hFF04, 16'hFF02};

    initial begin
        int lat, bcnt, dcnt;
        logic [15:0] dseen;

        rst = 1'b1; start = 1'b0; Aluctrl = 4'h0; din1 = '0; din2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout",   {16'h0, dout}, 32'h0);
        check("rst_mulreg", mulreg, 32'h0);
        check("rst_flags",  {29'h0, done, zeroflag, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a multiply.
        single_op(4'h0, 16'h1234, 16'h0001);
        check("pre_add", {16'h0, dout}, 32'h1235);
        @(negedge clk);
        start = 1'b1; Aluctrl = 4'hB; din1 = 16'hFF03; din2 = 16'h0001;
        @(posedge clk); #1;
        check("mulrst_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dout", {16'h0, dout}, 32'h0);
        check("async_rst_flags", {29'h0, done, zeroflag, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("aborted_no_done", dcnt, 0);
        single_op(4'h0, 16'h0001, 16'h0002);
        check("post_rst_add", {16'h0, dout}, 32'h0003);

        // Back-to-back sweep, start held every cycle.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start = 1'b1; Aluctrl = sw_op[i]; din1 = 16'hFF03; din2 = 16'h0001;
            @(posedge clk); #1;
            check($sformatf("sweep_dout_op%h", sw_op[i]), {16'h0, dout}, {16'h0, sw_exp[i]});
            check($sformatf("sweep_flags_op%h", sw_op[i]), {30'h0, done, zeroflag},
                  {30'h0, 1'b1, (sw_exp[i] == 16'h0)});
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_clears", {31'h0, done}, 32'h0);
        check("sweep_mulreg", mulreg, 32'h0);

        // Multiply FF03 x 0001.
        run_mul(16'hFF03, 16'h0001, lat, bcnt, dseen);
        check("mul1_latency", lat, 16);
        check("mul1_busy_cycles", bcnt, 16);
        check("mul1_dout_held", {16'h0, dseen}, 32'h0000FF02);
        check("mul1_mulreg", mulreg, 32'h0000FF03);
        check("mul1_dout", {16'h0, dout}, 32'h0000FF03);
        check("mul1_flags", {29'h0, done, zeroflag, busy}, 32'h4);
        @(posedge clk); #1;
        check("mul1_done_single", {31'h0, done}, 32'h0);

        // Multiply FFFF x FFFF, then ADD that wraps to zero.
        run_mul(16'hFFFF, 16'hFFFF, lat, bcnt, dseen);
        check("mul2_latency", lat, 16);
        check("mul2_mulreg", mulreg, 32'hFFFE0001);
        check("mul2_dout", {16'h0, dout}, 32'h0001);
        single_op(4'h0, 16'h0001, 16'hFFFF);
        check("wrap_add_dout", {16'h0, dout}, 32'h0);
        check("wrap_add_zero", {31'h0, zeroflag}, 32'h1);
        check("wrap_add_mulreg", mulreg, 32'hFFFE0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
